// File: rtl/neg_sub_arbiter_if.sv
// neg_sub_arbiter_if: request/grant and result handshake between the control
// front end (master) and the shared negate/subtract controller (slave).
interface neg_sub_arbiter_if #(
   parameter int WIDTH = 8
);
   logic             REQ0;
   logic             REQ1;
   logic             OP0;
   logic             OP1;
   logic [WIDTH-1:0] A0;
   logic [WIDTH-1:0] B0;
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] B1;
   logic             GNT0;
   logic             GNT1;
   logic             BUSY;
   logic             RES_VALID;
   logic             RES_READY;
   logic             RES_ID;
   logic [WIDTH-1:0] Y;
   logic             OVF;

   modport master (
      output REQ0, REQ1, OP0, OP1, A0, B0, A1, B1, RES_READY,
      input  GNT0, GNT1, BUSY, RES_VALID, RES_ID, Y, OVF
   );

   modport slave (
      input  REQ0, REQ1, OP0, OP1, A0, B0, A1, B1, RES_READY,
      output GNT0, GNT1, BUSY, RES_VALID, RES_ID, Y, OVF
   );
endinterface

// File: rtl/neg_sub_arbiter.sv
// neg_sub_arbiter: round-robin arbiter for two requesters sharing the
// two's-complement negate unit and a ripple adder. Negate takes one pass
// (T = ~A + 1); subtract negates B and then adds A (T = A + T).
// Optional build macro NEG_SUB_ARB_OVF_EN enables signed-overflow reporting
// on OVF; without it OVF is tied to 0 and no overflow logic exists.
module neg_sub_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   neg_sub_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NEG  = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [WIDTH-1:0] t_q, t_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic             id_q, id_d;
   logic             gnt0, gnt1;
   logic [WIDTH-1:0] neg_src;
   logic [WIDTH-1:0] sum;
`ifdef NEG_SUB_ARB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // Next-state, arbitration, operand capture and datapath loads for T
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      t_d     = t_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      id_d    = id_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      neg_src = op_q ? b_q : a_q;
      sum     = a_q + t_q;
`ifdef NEG_SUB_ARB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.REQ0 && (!bus.REQ1 || !ptr_q)) begin
               gnt0    = 1'b1;
               a_d     = bus.A0;
               b_d     = bus.B0;
               op_d    = bus.OP0;
               id_d    = 1'b0;
               ptr_d   = 1'b1;
               state_d = NEG;
            end else if (bus.REQ1) begin
               gnt1    = 1'b1;
               a_d     = bus.A1;
               b_d     = bus.B1;
               op_d    = bus.OP1;
               id_d    = 1'b1;
               ptr_d   = 1'b0;
               state_d = NEG;
            end
         end
         NEG: begin
            t_d     = ~neg_src + WIDTH'(1);
            state_d = op_q ? ADD : DONE;
`ifdef NEG_SUB_ARB_OVF_EN
            ovf_d   = !op_q && (a_q == MIN_NEG);
`endif
         end
         ADD: begin
            t_d     = sum;
            state_d = DONE;
`ifdef NEG_SUB_ARB_OVF_EN
            ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
`endif
         end
         DONE: begin
            if (bus.RES_READY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer and datapath registers; reset drops any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         t_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         t_q     <= t_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         id_q    <= id_d;
      end
   end

`ifdef NEG_SUB_ARB_OVF_EN
   // Overflow flag, settled by the last datapath pass before DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.OVF = (state_q == DONE) ? ovf_q : 1'b0;
`else
   assign bus.OVF = 1'b0;
`endif

   // Grants are gated by reset so every output is low while rst_n is asserted
   assign bus.GNT0      = gnt0 && rst_n;
   assign bus.GNT1      = gnt1 && rst_n;
   assign bus.BUSY      = (state_q != IDLE);
   assign bus.RES_VALID = (state_q == DONE);
   assign bus.RES_ID    = (state_q == DONE) ? id_q : 1'b0;
   assign bus.Y         = (state_q == DONE) ? t_q : '0;

endmodule

// File: doc/neg_sub_arbiter.md
# neg_sub_arbiter

Shared-resource controller for the ALU's two's-complement negate datapath (bitwise invert plus carry-in-one ripple adder) and a second ripple adder. It arbitrates two requesters round-robin, sequences negate (one pass) or subtract (negate B, then add A), and holds a registered result until the consumer accepts it. It sits between the control front end and the shared arithmetic units in the ALU.

## Interface
- WIDTH, 8, operand/result width in bits (two's complement).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- REQ0, REQ1  input  1  request from port 0 / port 1; held until granted.
- OP0, OP1  input  1  0 = negate (Y = -A), 1 = subtract (Y = A - B).
- A0, B0, A1, B1  input  WIDTH  operands per port; stable while REQ is high.
- GNT0, GNT1  output  1  one-cycle grant pulse; operands captured on this edge.
- BUSY  output  1  high in any state other than IDLE.
- RES_VALID  output  1  result available.
- RES_READY  input  1  consumer accepts result.
- RES_ID  output  1  port that issued the result.
- Y  output  WIDTH  result.
- OVF  output  1  signed overflow of the result.

## Operation
- FSM states: IDLE, NEG, ADD, DONE.
- IDLE: if any REQ is high, grant one (GNTx=1 combinationally in IDLE), capture A, B, OP and id into registers, then go to NEG. With no request, stay in IDLE.
- Arbitration: the round-robin pointer starts at port 0 after reset. On simultaneous requests the pointer port wins. After any grant, the pointer moves to the other port. A lone requester always wins.
- NEG: the register T is loaded with ~operand + 1. The operand is A for negate and B for subtract. Next state is DONE for negate and ADD for subtract.
- ADD: T is loaded with A + T, mod 2^WIDTH, carry discarded. Next state is DONE.
- DONE: Y = T and RES_VALID = 1. Y, RES_ID and OVF are held stable until RES_READY = 1 is sampled. Then go to IDLE; RES_VALID falls on the next edge.
- No grant is issued outside IDLE. Requests arriving while BUSY simply wait.
- Arithmetic wraps: -0x80 = 0x80, and 0x00 - 0x01 = 0xFF.
- Reset (asynchronous, at any time including mid-operation): state = IDLE, pointer = 0, T = 0. All outputs go to 0: GNT0, GNT1, BUSY, RES_VALID, RES_ID, Y, OVF. An in-flight operation is dropped with no result.

## Timing
- Grant at edge t (IDLE, REQ sampled).
- Negate: NEG runs in cycle t+1, and RES_VALID is high from edge t+2.
- Subtract: NEG in t+1, ADD in t+2, and RES_VALID is high from edge t+3.
- If RES_READY is already high, DONE lasts one cycle and the next grant is possible one cycle after leaving DONE.
- Minimum request spacing: 3 cycles for negate, 4 for subtract.

## Configuration
- NEG_SUB_ARB_OVF_EN defined: OVF is computed.
  - Negate: OVF = 1 iff A = 100…0.
  - Subtract: OVF = 1 iff sign(A) ≠ sign(B) and sign(Y) ≠ sign(A). The original B is used, so B = 0x80 is handled correctly.
- NEG_SUB_ARB_OVF_EN undefined: OVF is tied to 0 and no overflow logic is built.

## Test plan
- Reset, then REQ0 with OP0 = 0, A0 = 0x05: GNT0 at t, then Y = 0xFB, RES_ID = 0, OVF = 0, RES_VALID at t+2.
- REQ1 with OP1 = 1, A1 = 0x10, B1 = 0x03: Y = 0x0D at t+3. Then A1 = 0x00, B1 = 0x01: Y = 0xFF, OVF = 0.
- Overflow corners (with macro): negate 0x80 gives Y = 0x80, OVF = 1. Subtract 0x7F − 0x80 gives Y = 0xFF, OVF = 1. Without the macro, OVF = 0 in both cases.
- REQ0 and REQ1 both held high continuously: grants alternate 0, 1, 0, 1. Each grant occurs only in IDLE, and the first grant after reset goes to port 0.
- Hold RES_READY = 0 for 5 cycles in DONE: Y, RES_ID, OVF and RES_VALID stay stable, and no GNT is issued. Raise RES_READY: the FSM returns to IDLE the next cycle.
- Assert rst_n = 0 in the ADD state: all outputs go to 0 immediately, with no RES_VALID. After release, the pointer is 0 and a new request is granted.
